// File: rtl/ddr_init_seq_pkg.sv
// Shared DDR4 init definitions: FSM states, MR indices, command encodings,
// output pin bundle and default JEDEC-style timing values in controller cycles.
package ddr_init_seq_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned T_RST_DEF = 20;
  localparam int unsigned T_CKE_DEF = 50;
  localparam int unsigned T_XPR_DEF = 10;
  localparam int unsigned T_MRD_DEF = 8;
  localparam int unsigned T_MOD_DEF = 24;
  localparam int unsigned T_ZQ_DEF  = 64;

  typedef enum logic [2:0] {
    RST_HOLD, CKE_WAIT, XPR_WAIT, MRS_ISSUE, MRS_WAIT, ZQ_ISSUE, ZQ_WAIT, DONE
  } init_state_e;

  typedef enum logic [2:0] {
    MR0 = 3'd0, MR1 = 3'd1, MR2 = 3'd2, MR3 = 3'd3, MR4 = 3'd4, MR5 = 3'd5, MR6 = 3'd6
  } mr_idx_e;

  typedef struct packed {
    logic cs_n;
    logic act_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } cmd_t;

  localparam cmd_t CMD_DES  = cmd_t'(5'b11111);
  localparam cmd_t CMD_MRS  = cmd_t'(5'b01000);
  localparam cmd_t CMD_ZQCL = cmd_t'(5'b01110);

  typedef struct packed {
    logic              dimm_rst_n;
    logic              cke;
    cmd_t              cmd;
    logic [1:0]        bg;
    logic [1:0]        ba;
    logic [ADDR_W-1:0] addr;
    logic              init_done;
  } ddr_pins_t;

  localparam ddr_pins_t PINS_RST = '{
    dimm_rst_n: 1'b0, cke: 1'b0, cmd: CMD_DES, bg: 2'b00, ba: 2'b00,
    addr: '0, init_done: 1'b0
  };

  // Issue slot (0..6) to mode register: MR3, MR6, MR5, MR4, MR2, MR1, MR0.
  function automatic mr_idx_e mr_of_pos(input logic [2:0] pos);
    case (pos)
      3'd0:    return MR3;
      3'd1:    return MR6;
      3'd2:    return MR5;
      3'd3:    return MR4;
      3'd4:    return MR2;
      3'd5:    return MR1;
      default: return MR0;
    endcase
  endfunction

endpackage

// File: rtl/ddr_mr_encode.sv
// Combinational mapper from mode-register index to {bg, ba, addr} opcode,
// with the opcode fields fixed by the latency/burst/preamble parameters.
module ddr_mr_encode
  import ddr_init_seq_pkg::*;
#(
  parameter int         CAS_DLY      = 4,
  parameter int         WR_DLY       = 10,
  parameter int         AL_DLY       = 0,
  parameter logic [1:0] BURST_LENGTH = 2'b00,
  parameter logic       W_PRE        = 1'b1,
  parameter logic       R_PRE        = 1'b1
) (
  input  mr_idx_e           mr_idx_i,
  output logic [1:0]        bg_c,
  output logic [1:0]        ba_c,
  output logic [ADDR_W-1:0] addr_c
);

  localparam logic       AL_LEGAL = (AL_DLY == 0) || (AL_DLY == CAS_DLY - 1) ||
                                    (AL_DLY == CAS_DLY - 2);
  localparam logic [1:0] AL_CODE  = (AL_DLY == 0)           ? 2'b00 :
                                    (AL_DLY == CAS_DLY - 1) ? 2'b01 :
                                    (AL_DLY == CAS_DLY - 2) ? 2'b10 : 2'b00;
  localparam logic [2:0] CAS_CODE = 3'(CAS_DLY);
  localparam logic [2:0] WR_CODE  = 3'(WR_DLY - 9);

  logic [2:0] idx;
  assign idx = mr_idx_i;

  always_comb begin
    addr_c = '0;
    bg_c   = {1'b0, idx[2]};
    ba_c   = idx[1:0];
    case (mr_idx_i)
      MR0: begin
        addr_c[1:0] = BURST_LENGTH;
        addr_c[6:4] = CAS_CODE;
      end
      MR1: begin
        addr_c[0]   = 1'b1;
        addr_c[4:3] = AL_CODE;
      end
      MR2: addr_c[5:3] = WR_CODE;
      MR4: begin
        addr_c[11] = R_PRE;
        addr_c[12] = W_PRE;
      end
      default: ;
    endcase
  end

  // An unsupported additive latency falls back to AL=0; flag it when MR1 is formed.
  always_comb begin
    if (mr_idx_i == MR1) begin
      assert (AL_LEGAL) else $warning("ddr_mr_encode: illegal AL_DLY, MR1 AL encoded as 00");
    end
  end

endmodule

// File: rtl/ddr_init_seq.sv
// DDR4 power-up sequencer: reset/CKE timing, seven MRS writes, one ZQCL,
// then init_done. One down-counter times every wait; all pins are registered.
module ddr_init_seq
  import ddr_init_seq_pkg::*;
#(
  parameter int          CAS_DLY      = 4,
  parameter int          WR_DLY       = 10,
  parameter int          AL_DLY       = 0,
  parameter logic [1:0]  BURST_LENGTH = 2'b00,
  parameter logic        W_PRE        = 1'b1,
  parameter logic        R_PRE        = 1'b1,
  parameter int unsigned T_RST        = T_RST_DEF,
  parameter int unsigned T_CKE        = T_CKE_DEF,
  parameter int unsigned T_XPR        = T_XPR_DEF,
  parameter int unsigned T_MRD        = T_MRD_DEF,
  parameter int unsigned T_MOD        = T_MOD_DEF,
  parameter int unsigned T_ZQ         = T_ZQ_DEF
) (
  input  logic              i_cpu_ck,
  input  logic              reset_n,
  output logic              dimm_rst_n,
  output logic              cke,
  output logic              cs_n,
  output logic              act_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [1:0]        bg,
  output logic [1:0]        ba,
  output logic [ADDR_W-1:0] addr,
  output logic              init_done
);

  localparam logic [2:0] POS_MR0  = 3'd6;
  localparam logic [2:0] POS_DONE = 3'd7;

  init_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        pos_q, pos_d;
  logic              armed_q, armed_d;
  ddr_pins_t         pins_q, pins_d;

  logic [1:0]        enc_bg, enc_ba;
  logic [ADDR_W-1:0] enc_addr;
  logic [CNT_W-1:0]  cnt_dec;

  ddr_mr_encode #(
    .CAS_DLY      (CAS_DLY),
    .WR_DLY       (WR_DLY),
    .AL_DLY       (AL_DLY),
    .BURST_LENGTH (BURST_LENGTH),
    .W_PRE        (W_PRE),
    .R_PRE        (R_PRE)
  ) u_mr_encode (
    .mr_idx_i (mr_of_pos(pos_d)),
    .bg_c     (enc_bg),
    .ba_c     (enc_ba),
    .addr_c   (enc_addr)
  );

  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

  // Next state / counter; the MRS spacing and T_MOD are timed from the issue cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_dec;
    pos_d   = pos_q;
    armed_d = armed_q;
    case (state_q)
      RST_HOLD: begin
        if (!armed_q) begin
          cnt_d   = CNT_W'(T_RST - 1);
          armed_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = CKE_WAIT;
          cnt_d   = CNT_W'(T_CKE - 1);
        end
      end
      CKE_WAIT: if (cnt_q == '0) begin
        state_d = XPR_WAIT;
        cnt_d   = CNT_W'(T_XPR - 1);
      end
      XPR_WAIT: if (cnt_q == '0) begin
        state_d = MRS_ISSUE;
        cnt_d   = CNT_W'(T_MRD - 1);
      end
      MRS_ISSUE: begin
        state_d = MRS_WAIT;
        pos_d   = pos_q + 3'd1;
      end
      MRS_WAIT: if (cnt_q == '0) begin
        if (pos_q == POS_DONE) begin
          state_d = ZQ_ISSUE;
          cnt_d   = CNT_W'(T_ZQ - 1);
        end else begin
          state_d = MRS_ISSUE;
          cnt_d   = (pos_q == POS_MR0) ? CNT_W'(T_MOD - 1) : CNT_W'(T_MRD - 1);
        end
      end
      ZQ_ISSUE: state_d = ZQ_WAIT;
      ZQ_WAIT:  if (cnt_q == '0) state_d = DONE;
      DONE:     cnt_d = '0;
    endcase
  end

  // Pin values for the upcoming state, registered below.
  always_comb begin
    pins_d            = PINS_RST;
    pins_d.dimm_rst_n = (state_d != RST_HOLD);
    pins_d.cke        = (state_d != RST_HOLD) && (state_d != CKE_WAIT);
    pins_d.init_done  = (state_d == DONE);
    if (state_d == MRS_ISSUE) begin
      pins_d.cmd  = CMD_MRS;
      pins_d.bg   = enc_bg;
      pins_d.ba   = enc_ba;
      pins_d.addr = enc_addr;
    end else if (state_d == ZQ_ISSUE) begin
      pins_d.cmd      = CMD_ZQCL;
      pins_d.addr[10] = 1'b1;
    end
  end

  always_ff @(posedge i_cpu_ck or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RST_HOLD;
      cnt_q   <= '0;
      pos_q   <= '0;
      armed_q <= 1'b0;
      pins_q  <= PINS_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      armed_q <= armed_d;
      pins_q  <= pins_d;
    end
  end

  assign dimm_rst_n = pins_q.dimm_rst_n;
  assign cke        = pins_q.cke;
  assign cs_n       = pins_q.cmd.cs_n;
  assign act_n      = pins_q.cmd.act_n;
  assign ras_n      = pins_q.cmd.ras_n;
  assign cas_n      = pins_q.cmd.cas_n;
  assign we_n       = pins_q.cmd.we_n;
  assign bg         = pins_q.bg;
  assign ba         = pins_q.ba;
  assign addr       = pins_q.addr;
  assign init_done  = pins_q.init_done;

endmodule
